// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS-style constants and types for the fetch stage.
// Provides Instr, ADDRESS_WIDTH, INSTRUCTION_WIDTH, BPI, HALT_OPCODE and
// is_halt(). With IF_FETCH_COUNT_EN defined it also provides CountInstruction().
package mips_pkg;
  localparam int ADDRESS_WIDTH = 32;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int BPI = 4;
  localparam logic [5:0] HALT_OPCODE = 6'b010001;
  typedef logic [INSTRUCTION_WIDTH-1:0] Instr;
  function automatic logic is_halt(input Instr i);
    return i[INSTRUCTION_WIDTH-1 -: 6] == HALT_OPCODE;
  endfunction
`ifdef IF_FETCH_COUNT_EN
  function automatic void CountInstruction();
  endfunction
`endif
endpackage

// File: rtl/if_instr_buf.sv
// if_instr_buf: DEPTH-entry FIFO of {pc, instr} between fetch and decode.
// Ports: clk, rst_n (async active-low); push/push_pc/push_instr write side;
// pop/flush read and clear; head_pc/head_instr (zero when empty); full, empty, count.
module if_instr_buf
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [ADDRESS_WIDTH-1:0] push_pc,
  input  Instr                     push_instr,
  output logic [ADDRESS_WIDTH-1:0] head_pc,
  output Instr                     head_instr,
  output logic                     full,
  output logic                     empty,
  output logic [2:0]               count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic [ADDRESS_WIDTH-1:0] pc_mem_q [DEPTH];
  Instr instr_mem_q [DEPTH];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    wr_ptr_d   = flush ? '0 : push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = flush ? '0 : pop ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d    = flush ? '0 : count_q + 3'(push) - 3'(pop);
    empty      = count_q == '0;
    full       = count_q == 3'(DEPTH);
    count      = count_q;
    head_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];
    head_instr = empty ? '0 : instr_mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end

  always_ff @(posedge clk)
    if (push && !flush) begin
      pc_mem_q[wr_ptr_q]    <= push_pc;
      instr_mem_q[wr_ptr_q] <= push_instr;
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: credit-limited instruction fetch with redirect, discard and HALT.
// Ports: clk, rst_n (async active-low); imem_req_* request channel; imem_rsp_*
// in-order responses; redirect_valid/redirect_pc; id_valid/id_ready/id_instr/id_pc
// to decode; halted. Macro IF_FETCH_COUNT_EN adds output fetch_count (pop counter).
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                       BUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  Instr                     imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output Instr                     id_instr,
  output logic [ADDRESS_WIDTH-1:0] id_pc,
  output logic                     halted
`ifdef IF_FETCH_COUNT_EN
  ,
  output logic [31:0]              fetch_count
`endif
);
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redirect_tgt;
  logic [2:0] outstanding_q, outstanding_d, discard_q, discard_d, occ;
  logic halted_q, halted_d;
  logic rsp_fire, req_fire, push, pop, buf_full, buf_empty;

  always_comb begin
    redirect_tgt   = redirect_pc & ~ADDRESS_WIDTH'(3);
    // A response with nothing outstanding (e.g. left over from before reset) is ignored.
    rsp_fire       = imem_rsp_valid && outstanding_q != '0;
    push           = rsp_fire && discard_q == '0 && !halted_q && !redirect_valid;
    imem_req_valid = rst_n && !redirect_valid && !halted_q && !buf_full &&
                     ({1'b0, outstanding_q} + {1'b0, occ} < 4'(BUF_DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    id_valid       = !buf_empty && !redirect_valid;
    pop            = id_valid && id_ready;
    halted         = halted_q;
    fetch_pc_d     = redirect_valid ? redirect_tgt :
                     req_fire ? fetch_pc_q + ADDRESS_WIDTH'(BPI) : fetch_pc_q;
    // rsp_pc tracks the PC of the next response that will actually be buffered.
    rsp_pc_d       = redirect_valid ? redirect_tgt :
                     push ? rsp_pc_q + ADDRESS_WIDTH'(BPI) : rsp_pc_q;
    outstanding_d  = outstanding_q + 3'(req_fire) - 3'(rsp_fire);
    discard_d      = redirect_valid ? outstanding_q - 3'(rsp_fire) :
                     discard_q - 3'(rsp_fire && discard_q != '0);
    halted_d       = redirect_valid ? 1'b0 :
                     (push && is_halt(imem_rsp_data)) ? 1'b1 : halted_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      halted_q      <= halted_d;
    end

  if_instr_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (rsp_pc_q),
    .push_instr (imem_rsp_data),
    .head_pc    (id_pc),
    .head_instr (id_instr),
    .full       (buf_full),
    .empty      (buf_empty),
    .count      (occ)
  );

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  always_comb begin
    fetch_count_d = fetch_count_q + 32'(pop);
    fetch_count   = fetch_count_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fetch_count_q <= '0;
    else fetch_count_q <= fetch_count_d;
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (pop) CountInstruction();
`endif
`endif
endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the number of instruction buffer entries (legal range 2..4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1, memory accepts the request.
REQ-007 SHALL have port imem_req_addr, output, ADDRESS_WIDTH, byte address of the fetch.
REQ-008 SHALL have port imem_rsp_valid, input, 1, response valid; responses return in order, latency of 1 or more cycles.
REQ-009 SHALL have port imem_rsp_data, input, INSTRUCTION_WIDTH, fetched word.
REQ-010 SHALL have port redirect_valid, input, 1, branch/jump redirect from downstream.
REQ-011 SHALL have port redirect_pc, input, ADDRESS_WIDTH, redirect target.
REQ-012 SHALL have port id_valid, output, 1, instruction available to decode.
REQ-013 SHALL have port id_ready, input, 1, decode accepts the instruction.
REQ-014 SHALL have port id_instr, output, Instr, head-of-buffer instruction.
REQ-015 SHALL have port id_pc, output, ADDRESS_WIDTH, PC of id_instr.
REQ-016 SHALL have port halted, output, 1, a HALT instruction has been buffered and fetch is stopped.

Function
REQ-017 SHALL hold fetch_pc and issue imem_req_valid=1 only when outstanding + occupancy < BUF_DEPTH, halted=0 and redirect_valid=0.
REQ-018 SHALL advance fetch_pc by BPI (4) on each req handshake, wrapping modulo 2^32.
REQ-019 SHALL track outstanding requests (0..BUF_DEPTH) and write each non-discarded response, tagged with its request PC, into the buffer in the cycle it arrives.
REQ-020 SHALL drive id_valid=1 whenever the buffer is non-empty; a pop occurs on id_valid && id_ready; a simultaneous push and pop when full is impossible by REQ-017, and a simultaneous push and pop on a non-empty buffer SHALL keep occupancy unchanged.
REQ-021 SHALL, on redirect_valid=1, set fetch_pc to {redirect_pc[31:2],2'b00}, flush the buffer, clear halted, and mark all outstanding requests for discard; id_valid SHALL be 0 in that cycle and in the following cycle, and no request SHALL be issued in that cycle.
REQ-022 SHALL drop discarded responses without writing them to the buffer, decrementing the discard count; fetch credit SHALL return on each dropped response.
REQ-023 SHALL set halted on a buffer push of an instruction whose opcode is 6'b010001 (HALT), and SHALL drop later responses, discarding them as in REQ-022.
REQ-024 SHALL give redirect priority over a pop, a push and a halt detection in the same cycle.
REQ-025 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.

Reset
REQ-026 SHALL on rst_n=0 immediately set fetch_pc=RESET_PC, occupancy=0, outstanding=0, discard=0, halted=0, imem_req_valid=0, id_valid=0, id_instr=0, id_pc=0.
REQ-027 SHALL ignore responses arriving in the first cycle after reset release, and SHALL issue the first request in that cycle.

Configuration
REQ-028 SHALL, with IF_FETCH_COUNT_EN defined, add output fetch_count (32 bits, reset 0) that increments on each pop and wraps at 2^32, and SHALL call CountInstruction() on each pop in simulation; without the macro neither the port nor the counter exists.

Structure
REQ-029 SHALL take Instr, ADDRESS_WIDTH, INSTRUCTION_WIDTH, BPI and a new HALT_OPCODE constant from mips_pkg.
REQ-030 SHALL implement the buffer as sub-module if_instr_buf (a parameterised FIFO of {pc, instr}, with push, pop, flush, full and empty).

Verification
REQ-031 Reset, 1-cycle memory, id_ready=1 -> addresses 0, 4, 8, ... issued; id_pc sequence 0, 4, 8 with matching data.
REQ-032 id_ready=0 for 10 cycles -> exactly BUF_DEPTH requests issued; no overflow; order preserved on release.
REQ-033 Redirect to 0x103 with 2 requests in flight -> next request address is 0x100; both stale responses are dropped; first id_pc is 0x100.
REQ-034 HALT word 0x4400_0000 fetched at 0x8 -> halted=1 and no further requests; a redirect to 0x20 clears halted and fetch resumes at 0x20.
REQ-035 imem_req_ready held low 3 cycles -> imem_req_addr stays constant; fetch_pc advances only on the handshake.
REQ-036 rst_n asserted mid-stream with responses pending -> outputs go to their reset values immediately and late responses are ignored.
